// File: rtl/key_debounce_if.sv
// -----------------------------------------------------------------------------
// key_debounce_if
//   Bundle of key-level signals between the board-side key source and the
//   key_debounce block.
//
//   Signals:
//     SW_RAW      [7:0]  raw key levels, asynchronous, 0 = pressed
//     SW_DB       [7:0]  debounced key levels, 0 = pressed
//     PRESS       [7:0]  one-cycle strobe per key on accepted press
//     RELEASE     [7:0]  one-cycle strobe per key on accepted release
//     NOTE_IDX    [2:0]  index of highest-numbered key currently pressed
//     NOTE_VALID         1 when at least one key is pressed
//
//   Modports:
//     master  key source / consumer side (drives SW_RAW, observes results)
//     slave   key_debounce side (samples SW_RAW, drives results)
// -----------------------------------------------------------------------------
interface key_debounce_if;

    logic [7:0] SW_RAW;
    logic [7:0] SW_DB;
    logic [7:0] PRESS;
    logic [7:0] RELEASE;
    logic [2:0] NOTE_IDX;
    logic       NOTE_VALID;

    modport master (
        output SW_RAW,
        input  SW_DB,
        input  PRESS,
        input  RELEASE,
        input  NOTE_IDX,
        input  NOTE_VALID
    );

    modport slave (
        input  SW_RAW,
        output SW_DB,
        output PRESS,
        output RELEASE,
        output NOTE_IDX,
        output NOTE_VALID
    );

endinterface

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
//   Input stage for the 8-key piano tone generator. Each raw switch level is
//   synchronised through two flops, debounced by a per-key counter, and
//   presented as a clean active-low level on SW_DB. Registered press/release
//   strobes and a priority-encoded note index accompany the levels.
//
//   Parameters:
//     DEBOUNCE_CYCLES  cycles a synchronised level must persist (2 .. 2^24-1)
//     NUM_KEYS         number of keys, fixed at 8
//
//   Ports:
//     CLK_IN   system clock (12 MHz)
//     RST_N    synchronous, active-low reset
//     kif      key_debounce_if.slave: SW_RAW in; SW_DB, PRESS, RELEASE,
//              NOTE_IDX, NOTE_VALID out
//
//   Build option:
//     KEY_TOGGLE_EN  when defined, each accepted press toggles a per-key latch
//                    and SW_DB (and the note encoder) follow the latch, so a
//                    first press holds a note and a second press silences it.
//                    PRESS/RELEASE still follow the physical debounced key.
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000,
    parameter int NUM_KEYS        = 8
) (
    input  logic         CLK_IN,
    input  logic         RST_N,
    key_debounce_if.slave kif
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] stable_q;
    logic [NUM_KEYS-1:0] stable_d;
    logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
    logic [NUM_KEYS-1:0] press_d;
    logic [NUM_KEYS-1:0] release_d;
    logic [NUM_KEYS-1:0] press_q;
    logic [NUM_KEYS-1:0] release_q;
    logic [NUM_KEYS-1:0] sw_db;
    logic [2:0]          note_idx_q;
    logic [2:0]          note_idx_d;
    logic                note_valid_q;
    logic                note_valid_d;

    // -------------------------------------------------------------------------
    // Per-key debounce: count while the synchronised level disagrees with the
    // accepted level; accept on the cycle the count has reached its ceiling.
    // Any agreeing sample throws the partial count away.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so
        // no path leaves it unassigned (which would infer a latch).
        stable_d = stable_q;
        cnt_d    = '{default: '0};
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        // Active-low levels: a 1 -> 0 transition is a press.
        press_d   = stable_q & ~stable_d;
        release_d = ~stable_q & stable_d;
    end

    // -------------------------------------------------------------------------
    // Output level selection
    // -------------------------------------------------------------------------
`ifdef KEY_TOGGLE_EN
    logic [NUM_KEYS-1:0] latch_q;

    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            latch_q <= '1;
        end else begin
            latch_q <= latch_q ^ press_d;
        end
    end

    assign sw_db = latch_q;
`else
    assign sw_db = stable_q;
`endif

    // -------------------------------------------------------------------------
    // Note encoder: highest-numbered pressed key wins; index is held while no
    // key is down so display logic keeps showing the last note.
    // -------------------------------------------------------------------------
    always_comb begin
        note_valid_d = |(~sw_db);
        note_idx_d   = note_idx_q;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!sw_db[i]) begin
                note_idx_d = 3'(i);
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers (synchronous reset)
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK_IN) begin
        if (!RST_N) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            stable_q     <= '1;
            press_q      <= '0;
            release_q    <= '0;
            note_idx_q   <= '0;
            note_valid_q <= 1'b0;
            // NOTE: the counter array is reset explicitly so a reset arriving
            // mid-debounce discards any partial count.
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q      <= kif.SW_RAW;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            press_q      <= press_d;
            release_q    <= release_d;
            note_idx_q   <= note_idx_d;
            note_valid_q <= note_valid_d;
            for (int i = 0; i < NUM_KEYS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign kif.SW_DB      = sw_db;
    assign kif.PRESS      = press_q;
    assign kif.RELEASE    = release_q;
    assign kif.NOTE_IDX   = note_idx_q;
    assign kif.NOTE_VALID = note_valid_q;

endmodule

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
//   Directed self-checking bench for key_debounce with DEBOUNCE_CYCLES = 4.
//   Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int DC = 4;

    logic CLK_IN;
    logic RST_N;
    int   checks;
    int   errors;

    key_debounce_if kif ();

    key_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .NUM_KEYS       (8)
    ) dut (
        .CLK_IN(CLK_IN),
        .RST_N (RST_N),
        .kif   (kif)
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle to the following falling edge.
    task automatic step();
        @(posedge CLK_IN);
        @(negedge CLK_IN);
    endtask

    // Drive a new raw level, then walk the DC+2 edges to acceptance: no change
    // or strobe on edges 1..DC+1, expected level and strobes on edge DC+2.
    task automatic settle(input string tag, input logic [7:0] raw,
                          input logic [7:0] db_before, input logic [7:0] db_after,
                          input logic [7:0] press_exp, input logic [7:0] rel_exp);
        kif.SW_RAW = raw;
        for (int e = 1; e <= DC + 1; e++) begin
            step();
            check({tag, "_hold_db"}, 32'(kif.SW_DB), 32'(db_before));
            check({tag, "_hold_strobe"}, 32'({kif.PRESS, kif.RELEASE}), 32'(0));
        end
        step();
        check({tag, "_db"}, 32'(kif.SW_DB), 32'(db_after));
        check({tag, "_press"}, 32'(kif.PRESS), 32'(press_exp));
        check({tag, "_release"}, 32'(kif.RELEASE), 32'(rel_exp));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        RST_N      = 1'b0;
        kif.SW_RAW = 8'hFF;
        step();
        step();
        RST_N = 1'b1;

        // Reset state
        check("rst_db", 32'(kif.SW_DB), 32'hFF);
        check("rst_press", 32'(kif.PRESS), 32'h0);
        check("rst_release", 32'(kif.RELEASE), 32'h0);
        check("rst_idx", 32'(kif.NOTE_IDX), 32'h0);
        check("rst_valid", 32'(kif.NOTE_VALID), 32'h0);

        // Idle for 10 cycles
        for (int c = 0; c < 10; c++) begin
            step();
            check("idle_db", 32'(kif.SW_DB), 32'hFF);
            check("idle_strobe", 32'({kif.PRESS, kif.RELEASE}), 32'h0);
            check("idle_valid", 32'(kif.NOTE_VALID), 32'h0);
        end

`ifndef KEY_TOGGLE_EN
        // Key 3 press: accepted on edge 6, encoder one cycle later
        settle("k3_press", 8'hF7, 8'hFF, 8'hF7, 8'h08, 8'h00);
        check("k3_valid_lag", 32'(kif.NOTE_VALID), 32'h0);
        step();
        check("k3_press_1cyc", 32'(kif.PRESS), 32'h0);
        check("k3_idx", 32'(kif.NOTE_IDX), 32'h3);
        check("k3_valid", 32'(kif.NOTE_VALID), 32'h1);

        // Key 3 release: index held after NOTE_VALID drops
        settle("k3_rel", 8'hFF, 8'hF7, 8'hFF, 8'h00, 8'h08);
        step();
        check("k3_rel_valid", 32'(kif.NOTE_VALID), 32'h0);
        check("k3_rel_idx_hold", 32'(kif.NOTE_IDX), 32'h3);

        // Key 5 glitches: 3 cycles low, 3 high, five times; never accepted
        for (int g = 0; g < 5; g++) begin
            kif.SW_RAW = 8'hDF;
            for (int c = 0; c < 3; c++) begin
                step();
                check("k5_glitch_db", 32'(kif.SW_DB), 32'hFF);
                check("k5_glitch_press", 32'(kif.PRESS), 32'h0);
            end
            kif.SW_RAW = 8'hFF;
            for (int c = 0; c < 3; c++) begin
                step();
                check("k5_glitch_db", 32'(kif.SW_DB), 32'hFF);
                check("k5_glitch_press", 32'(kif.PRESS), 32'h0);
            end
        end

        // Keys 1 and 6 together, then release key 6
        settle("k16_press", 8'hBD, 8'hFF, 8'hBD, 8'h42, 8'h00);
        step();
        check("k16_idx", 32'(kif.NOTE_IDX), 32'h6);
        check("k16_valid", 32'(kif.NOTE_VALID), 32'h1);
        settle("k6_rel", 8'hFD, 8'hBD, 8'hFD, 8'h00, 8'h40);
        check("k6_rel_idx_lag", 32'(kif.NOTE_IDX), 32'h6);
        check("k6_rel_valid_lag", 32'(kif.NOTE_VALID), 32'h1);
        step();
        check("k6_rel_idx", 32'(kif.NOTE_IDX), 32'h1);
        check("k6_rel_valid", 32'(kif.NOTE_VALID), 32'h1);
        settle("k1_rel", 8'hFF, 8'hFD, 8'hFF, 8'h00, 8'h02);
        step();
        check("k1_rel_valid", 32'(kif.NOTE_VALID), 32'h0);
        check("k1_rel_idx_hold", 32'(kif.NOTE_IDX), 32'h1);

        // Key 0 pressed, reset when its counter reaches 2 (after edge 4)
        kif.SW_RAW = 8'hFE;
        for (int c = 0; c < 4; c++) begin
            step();
            check("k0_pre_db", 32'(kif.SW_DB), 32'hFF);
        end
        RST_N = 1'b0;
        step();
        RST_N = 1'b1;
        check("k0_rst_db", 32'(kif.SW_DB), 32'hFF);
        check("k0_rst_strobe", 32'({kif.PRESS, kif.RELEASE}), 32'h0);
        check("k0_rst_idx", 32'(kif.NOTE_IDX), 32'h0);
        check("k0_rst_valid", 32'(kif.NOTE_VALID), 32'h0);
        settle("k0_after_rst", 8'hFE, 8'hFF, 8'hFE, 8'h01, 8'h00);
        step();
        check("k0_release_none", 32'(kif.RELEASE), 32'h0);
        check("k0_idx", 32'(kif.NOTE_IDX), 32'h0);
        check("k0_valid", 32'(kif.NOTE_VALID), 32'h1);
        settle("k0_rel", 8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h01);
`else
        // Toggle mode: first press latches key 2 down, second press releases it
        settle("t2_press1", 8'hFB, 8'hFF, 8'hFB, 8'h04, 8'h00);
        step();
        check("t2_idx", 32'(kif.NOTE_IDX), 32'h2);
        check("t2_valid", 32'(kif.NOTE_VALID), 32'h1);
        settle("t2_rel1", 8'hFF, 8'hFB, 8'hFB, 8'h00, 8'h04);
        step();
        check("t2_rel1_valid", 32'(kif.NOTE_VALID), 32'h1);
        settle("t2_press2", 8'hFB, 8'hFB, 8'hFF, 8'h04, 8'h00);
        step();
        check("t2_press2_valid", 32'(kif.NOTE_VALID), 32'h0);
        settle("t2_rel2", 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h04);
        step();
        check("t2_rel2_valid", 32'(kif.NOTE_VALID), 32'h0);
        check("t2_idx_hold", 32'(kif.NOTE_IDX), 32'h2);
`endif

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
